mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, busy duration in cycles of mult/multu (legal 1..15).
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, busy duration in cycles of div/divu (legal 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  Execute-stage request qualifier for mdop.
REQ-006 SHALL have port mdop  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op.
REQ-007 SHALL have port A  input  32  forwarded rs operand from the D/E register.
REQ-008 SHALL have port B  input  32  forwarded rt operand from the D/E register.
REQ-009 SHALL have port busy  output  1  operation in flight.
REQ-010 SHALL have port stall_req  output  1  combinational busy | (start & mdop in {000..011}); used by the hazard unit to stall Decode.
REQ-011 SHALL have port HI  output  32  HI register.
REQ-012 SHALL have port LO  output  32  LO register.

Function
REQ-013 SHALL implement FSM IDLE/BUSY with a 4-bit down-counter.
REQ-014 IDLE + start + mdop in {000..011} SHALL latch the operands and op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY; busy=1 from the following cycle.
REQ-015 In BUSY the counter SHALL decrement each cycle; busy SHALL stay high exactly N cycles (N = loaded count).
REQ-016 On the final BUSY cycle's edge, HI/LO SHALL update and the FSM SHALL return to IDLE; new HI/LO and busy=0 SHALL be visible together.
REQ-017 mult SHALL form the signed 64-bit product {HI,LO}; multu SHALL form the unsigned product.
REQ-018 div SHALL give LO = quotient truncated toward zero and HI = remainder with the dividend's sign; divu SHALL give the unsigned quotient and remainder.
REQ-019 Division with B==0 SHALL take the full DIV_CYCLES and leave HI/LO unchanged.
REQ-020 mthi/mtlo in IDLE with start SHALL write A to HI/LO at that edge, with no busy.
REQ-021 Any start while busy=1 SHALL be ignored (no restart, no mthi/mtlo write); upstream stalls via stall_req.
REQ-022 start=0 or a no-op mdop SHALL leave all state unchanged.
REQ-023 HI/LO SHALL hold their values whenever not being written.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE, counter=0, busy=0, HI=0, LO=0, regardless of state, including mid-operation.
REQ-025 reset SHALL take priority over start in the same cycle; the aborted operation SHALL leave no trace.

Configuration
REQ-026 Macro MDU_DIV_EN defined: div/divu SHALL behave per REQ-014..019.
REQ-027 Macro MDU_DIV_EN undefined: the divider SHALL be absent; mdop 010/011 SHALL act as no-op (busy=0, stall_req=0, HI/LO unchanged).

Verification
REQ-028 mult A=0xFFFFFFFF B=0x00000002 -> busy high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE.
REQ-029 multu A=0xFFFFFFFF B=0x00000002 -> HI=0x00000001 LO=0xFFFFFFFE after 5 busy cycles.
REQ-030 div A=0xFFFFFFF9 B=0x00000002 -> busy 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; divu with the same operands -> LO=0x7FFFFFFC HI=0x00000001.
REQ-031 div A=5 B=0 with HI=LO=0x11111111 -> busy 10 cycles, HI/LO unchanged; mult issued at busy cycle 2 -> ignored, and stall_req=1 throughout.
REQ-032 mthi A=0x12345678 in IDLE -> HI=0x12345678 next cycle, busy stays 0; mtlo during busy -> LO unchanged.
REQ-033 reset asserted in busy cycle 3 of div -> next cycle busy=0, HI=LO=0; a mult issued afterwards completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and an IDLE/BUSY down-counter FSM.
// Optional divider enabled by defining MDU_DIV_EN; without it div/divu are no-ops.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_signed;
  logic [31:0] r_a, r_b, r_hi, r_lo;

  logic        w_is_mul, w_is_div;
  logic signed [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [31:0] w_res_hi, w_res_lo;

  assign w_is_mul = (mdop[2:1] == 2'b00);
  assign w_sprod  = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_uprod  = {32'd0, r_a} * {32'd0, r_b};

`ifdef MDU_DIV_EN
  logic               r_isdiv;
  logic signed [31:0] w_sa, w_sb;
  logic [31:0]        w_q, w_r;

  assign w_is_div = (mdop[2:1] == 2'b01);
  assign w_sa     = $signed(r_a);
  assign w_sb     = $signed(r_b);

  // Divide by zero keeps HI/LO; divide by -1 is negation so the min/-1 overflow never reaches '/'.
  always_comb begin
    w_q = r_lo;
    w_r = r_hi;
    if (r_b == 32'd0) begin
      w_q = r_lo;
      w_r = r_hi;
    end else if (!r_signed) begin
      w_q = r_a / r_b;
      w_r = r_a % r_b;
    end else if (r_b == 32'hFFFF_FFFF) begin
      w_q = 32'd0 - r_a;
      w_r = 32'd0;
    end else begin
      w_q = w_sa / w_sb;
      w_r = w_sa % w_sb;
    end
  end

  always_comb begin
    w_res_hi = r_signed ? w_sprod[63:32] : w_uprod[63:32];
    w_res_lo = r_signed ? w_sprod[31:0]  : w_uprod[31:0];
    if (r_isdiv) begin
      w_res_hi = w_r;
      w_res_lo = w_q;
    end
  end
`else
  assign w_is_div = 1'b0;
  assign w_res_hi = r_signed ? w_sprod[63:32] : w_uprod[63:32];
  assign w_res_lo = r_signed ? w_sprod[31:0]  : w_uprod[31:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_busy   <= 1'b0;
      r_signed <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
`ifdef MDU_DIV_EN
      r_isdiv  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          if (w_is_mul || w_is_div) begin
            r_a      <= A;
            r_b      <= B;
            r_signed <= ~mdop[0];
`ifdef MDU_DIV_EN
            r_isdiv  <= w_is_div;
`endif
            r_cnt    <= w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            r_busy   <= 1'b1;
            r_state  <= S_BUSY;
          end else if (mdop == 3'b100) begin
            r_hi <= A;
          end else if (mdop == 3'b101) begin
            r_lo <= A;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign stall_req = r_busy | (start & (w_is_mul | w_is_div));
  assign HI        = r_hi;
  assign LO        = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, hand-written corner sequences,
// and randomized ops against an arithmetic reference model.
module tb_mult_div_unit;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdop = 3'b111;
  logic [31:0] A = '0, B = '0;
  logic        busy, stall_req;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop), .A(A), .B(B),
    .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    int          cyc;
    logic [31:0] hi, lo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit is_md(input logic [2:0] op);
    return (op <= 3'd1) || (DIV_EN && op <= 3'd3);
  endfunction

  // Reference: results straight from 64-bit integer arithmetic.
  function automatic void model(input bit st, input logic [2:0] op, input logic [31:0] a, b,
                                inout logic [31:0] hi, lo, output int cyc);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    cyc = 0;
    if (!st) return;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    case (op)
      3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; cyc = MC; end
      3'd1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; cyc = MC; end
      3'd2: if (DIV_EN) begin
        cyc = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      end
      3'd3: if (DIV_EN) begin
        cyc = DC;
        if (b != 0) begin uq = ua / ub; ur = ua % ub; hi = ur[31:0]; lo = uq[31:0]; end
      end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endfunction

  task automatic issue(input bit st, input logic [2:0] op, input logic [31:0] a, b);
    @(negedge clk);
    start = st; mdop = op; A = a; B = b;
    #1 chk("stall_req on request", {31'd0, stall_req}, {31'd0, st & is_md(op)});
    @(negedge clk);
    start = 1'b0; mdop = 3'b111;
  endtask

  task automatic run(input bit st, input logic [2:0] op, input logic [31:0] a, b, output int cyc);
    issue(st, op, a, b);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t tbl[$];
  logic [31:0] ehi, elo;
  int cyc, n;

  initial begin
    tbl.push_back('{3'd0, 32'hFFFFFFFF, 32'h00000002, MC, 32'hFFFFFFFF, 32'hFFFFFFFE});
    tbl.push_back('{3'd1, 32'hFFFFFFFF, 32'h00000002, MC, 32'h00000001, 32'hFFFFFFFE});
    tbl.push_back('{3'd2, 32'hFFFFFFF9, 32'h00000002, DC, 32'hFFFFFFFF, 32'hFFFFFFFD});
    tbl.push_back('{3'd3, 32'hFFFFFFF9, 32'h00000002, DC, 32'h00000001, 32'h7FFFFFFC});
    tbl.push_back('{3'd0, 32'h00000007, 32'hFFFFFFFD, MC, 32'hFFFFFFFF, 32'hFFFFFFEB});
    tbl.push_back('{3'd4, 32'h12345678, 32'h0,        0,  32'h12345678, 32'hFFFFFFEB});
    tbl.push_back('{3'd5, 32'hCAFEF00D, 32'h0,        0,  32'h12345678, 32'hCAFEF00D});
    tbl.push_back('{3'd6, 32'h00000001, 32'h1,        0,  32'h12345678, 32'hCAFEF00D});
    tbl.push_back('{3'd1, 32'h80000000, 32'h80000000, MC, 32'h40000000, 32'h00000000});
    tbl.push_back('{3'd2, 32'h80000000, 32'hFFFFFFFF, DC, 32'h00000000, 32'h80000000});
    tbl.push_back('{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, DC, 32'hFFFFFFFF, 32'h00000003});
    tbl.push_back('{3'd3, 32'h00000064, 32'h00000007, DC, 32'h00000002, 32'h0000000E});
    tbl.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MC, 32'hFFFFFFFE, 32'h00000001});
    tbl.push_back('{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, MC, 32'h00000000, 32'h00000001});

    do_reset();
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset stall_req", {31'd0, stall_req}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);

    // Vector table; div entries collapse to no-ops when the divider is built out.
    ehi = 32'd0; elo = 32'd0;
    foreach (tbl[i]) begin
      run(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, cyc);
      if (!DIV_EN && (tbl[i].op == 3'd2 || tbl[i].op == 3'd3)) begin
        chk($sformatf("tbl%0d cycles", i), cyc, 32'd0);
      end else begin
        chk($sformatf("tbl%0d cycles", i), cyc, tbl[i].cyc);
        ehi = tbl[i].hi; elo = tbl[i].lo;
      end
      chk($sformatf("tbl%0d HI", i), HI, ehi);
      chk($sformatf("tbl%0d LO", i), LO, elo);
    end

    // Requests arriving mid-operation are dropped; stall_req holds throughout.
    issue(1'b1, 3'd0, 32'd3, 32'd4);
    n = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      n++;
      chk("stall_req while busy", {31'd0, stall_req}, 32'd1);
      if (n == 2) begin start = 1'b1; mdop = 3'd0; A = 32'd7; B = 32'd7; end
      else if (n == 3) begin start = 1'b1; mdop = 3'd5; A = 32'hDEADBEEF; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore cycles", n, MC);
    chk("ignore HI", HI, 32'd0);
    chk("ignore LO", LO, 32'd12);

    // Divide by zero: full latency, HI/LO untouched (or pure no-op without divider).
    run(1'b1, 3'd4, 32'h11111111, 32'd0, cyc);
    run(1'b1, 3'd5, 32'h11111111, 32'd0, cyc);
    issue(1'b1, 3'd2, 32'd5, 32'd0);
    n = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      n++;
      chk("div0 stall_req", {31'd0, stall_req}, 32'd1);
      start = (n == 2); mdop = 3'd0; A = 32'd2; B = 32'd2;
      @(negedge clk);
    end
    start = 1'b0;
    chk("div0 cycles", n, DIV_EN ? DC : 0);
    chk("div0 HI", HI, 32'h11111111);
    chk("div0 LO", LO, 32'h11111111);

    // Reset in busy cycle 3 wins over a simultaneous start and clears everything.
    issue(1'b1, DIV_EN ? 3'd2 : 3'd0, 32'd9, 32'd2);
    n = 0;
    for (int k = 0; k < 40 && busy && n < 3; k++) begin
      n++;
      if (n < 3) @(negedge clk);
    end
    reset = 1'b1; start = 1'b1; mdop = 3'd4; A = 32'hABCDABCD;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; mdop = 3'b111;
    #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset HI", HI, 32'd0);
    chk("midreset LO", LO, 32'd0);
    run(1'b1, 3'd0, 32'hFFFFFFFF, 32'd2, cyc);
    chk("post-reset mult cycles", cyc, MC);
    chk("post-reset mult HI", HI, 32'hFFFFFFFF);
    chk("post-reset mult LO", LO, 32'hFFFFFFFE);

    // Randomized traffic against the reference model.
    do_reset();
    ehi = 32'd0; elo = 32'd0;
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      bit          st;
      int          ecyc;
      op = 3'($urandom_range(0, 7));
      st = ($urandom_range(0, 7) != 0);
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      model(st, op, a, b, ehi, elo, ecyc);
      run(st, op, a, b, cyc);
      chk($sformatf("rnd%0d op%0d cycles", i, op), cyc, ecyc);
      chk($sformatf("rnd%0d op%0d HI", i, op), HI, ehi);
      chk($sformatf("rnd%0d op%0d LO", i, op), LO, elo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
